// File: rtl/pixel_write_queue.sv
// pixel_write_queue: buffers plotted pixels in a small FIFO and turns each
// one into a single-cycle framebuffer write at address Y*160 + X. Writes
// give way to the VGA scan-out reader, which reserves the RAM one cycle
// ahead. A clear engine can flood the framebuffer with one colour, and
// pushes are still accepted while it runs.
module pixel_write_queue #(
  parameter int X_SCREENSIZE = 160,
  parameter int Y_SCREENSIZE = 120,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_WIDTH   = 15
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic [7:0]                    iX,
  input  logic [6:0]                    iY,
  input  logic [2:0]                    iColour,
  input  logic                          iPlot,
  input  logic                          iClear,
  input  logic [2:0]                    iClearColour,
  input  logic                          iScanBusy,
  output logic [ADDR_WIDTH-1:0]         oWrAddr,
  output logic [2:0]                    oWrData,
  output logic                          oWrEn,
  output logic                          oFull,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel,
  output logic                          oOverflow,
  output logic                          oClearing
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(X_SCREENSIZE * Y_SCREENSIZE - 1);
  localparam logic [LVL_W-1:0]      FULL_COUNT = LVL_W'(FIFO_DEPTH);
  localparam logic [8:0]            X_LIMIT    = 9'(X_SCREENSIZE);
  localparam logic [7:0]            Y_LIMIT    = 8'(Y_SCREENSIZE);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  // Raw coordinates are stored; the address is formed at pop time.
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } entry_t;

  state_t state, state_next;

  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [LVL_W-1:0] count;

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [2:0]            clr_colour;

  logic                  push_valid, push, pop, lost, full;
  logic                  clr_start, clr_wr;
  entry_t                head;
  logic [ADDR_WIDTH-1:0] head_addr;

  // Push qualification, acceptance and head-of-queue address arithmetic.
  always_comb begin
    push_valid = iPlot && ({1'b0, iX} < X_LIMIT) && ({1'b0, iY} < Y_LIMIT);
    full       = (count == FULL_COUNT);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push       = push_valid && (!full || pop);
    lost       = push_valid && !push;
    head       = fifo_mem[rd_ptr];
    // Y*160 as (Y<<7) + (Y<<5), avoiding a multiplier.
    head_addr  = (ADDR_WIDTH'(head.y) << 7) + (ADDR_WIDTH'(head.y) << 5)
               + ADDR_WIDTH'(head.x);
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    clr_start  = 1'b0;
    clr_wr     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (iClear) begin
          state_next = ST_CLEAR;
          clr_start  = 1'b1;
        end else if (count != '0 && !iScanBusy) begin
          pop = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (!iScanBusy) begin
          clr_wr = 1'b1;
          if (clr_addr == LAST_ADDR) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FIFO storage; pointers and count below carry the reset.
  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr] <= '{x: iX, y: iY, colour: iColour};
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear engine: latches the fill colour and walks the address space.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      clr_addr   <= '0;
      clr_colour <= '0;
    end else if (clr_start) begin
      clr_addr   <= '0;
      clr_colour <= iClearColour;
    end else if (clr_wr) begin
      clr_addr   <= clr_addr + ADDR_WIDTH'(1);
    end
  end

  // Registered write port; address and data hold when no write is issued.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      oWrEn   <= 1'b0;
      oWrAddr <= '0;
      oWrData <= '0;
    end else if (pop) begin
      oWrEn   <= 1'b1;
      oWrAddr <= head_addr;
      oWrData <= head.colour;
    end else if (clr_wr) begin
      oWrEn   <= 1'b1;
      oWrAddr <= clr_addr;
      oWrData <= clr_colour;
    end else begin
      oWrEn   <= 1'b0;
    end
  end

  // Sticky overflow flag for lost pushes.
  always_ff @(posedge Clock) begin
    if (!Resetn)   oOverflow <= 1'b0;
    else if (lost) oOverflow <= 1'b1;
  end

  assign oLevel    = count;
  assign oFull     = full;
  assign oClearing = (state == ST_CLEAR);

endmodule

// File: tb/tb_pixel_write_queue.sv
// Bench for pixel_write_queue: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_pixel_write_queue;

  logic        Clock = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  colour = '0;
  logic        plot = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        scan_busy = 1'b0;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_en, full, overflow, clearing;
  logic [4:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_write_queue #(
    .X_SCREENSIZE(160),
    .Y_SCREENSIZE(120),
    .FIFO_DEPTH(16),
    .ADDR_WIDTH(15)
  ) dut (
    .Clock(Clock), .Resetn(resetn),
    .iX(x), .iY(y), .iColour(colour), .iPlot(plot),
    .iClear(clear), .iClearColour(clear_colour), .iScanBusy(scan_busy),
    .oWrAddr(wr_addr), .oWrData(wr_data), .oWrEn(wr_en),
    .oFull(full), .oLevel(level), .oOverflow(overflow), .oClearing(clearing)
  );

  always #5 Clock = ~Clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pixel queue plus clear progress.
  typedef struct { int px; int py; int pc; } pix_t;
  pix_t mq[$];
  bit   m_clearing, m_ovf, m_we, m_busy_edge;
  int   m_caddr, m_ccol, m_addr, m_data;

  function automatic void model_step();
    int   n;
    bit   do_pop;
    pix_t p;
    m_busy_edge = resetn && scan_busy;
    if (!resetn) begin
      mq.delete();
      m_clearing = 0; m_caddr = 0; m_ccol = 0; m_ovf = 0;
      m_we = 0; m_addr = 0; m_data = 0;
      return;
    end
    n = mq.size();
    do_pop = 0;
    m_we = 0;
    if (!m_clearing) begin
      if (clear) begin
        m_clearing = 1; m_caddr = 0; m_ccol = int'(clear_colour);
      end else if (n > 0 && !scan_busy) begin
        do_pop = 1;
      end
    end else if (!scan_busy) begin
      m_we = 1; m_addr = m_caddr; m_data = m_ccol;
      if (m_caddr == 160 * 120 - 1) m_clearing = 0;
      else m_caddr++;
    end
    if (do_pop) begin
      p = mq.pop_front();
      m_we = 1; m_addr = p.py * 160 + p.px; m_data = p.pc;
    end
    if (plot && int'(x) < 160 && int'(y) < 120) begin
      if (n < 16 || do_pop) begin
        p.px = int'(x); p.py = int'(y); p.pc = int'(colour);
        mq.push_back(p);
      end else begin
        m_ovf = 1;
      end
    end
  endfunction

  task automatic compare_all();
    check("wr_en",    32'(wr_en),    32'(m_we));
    check("wr_addr",  32'(wr_addr),  32'(m_addr));
    check("wr_data",  32'(wr_data),  32'(m_data));
    check("level",    32'(level),    32'(mq.size()));
    check("full",     32'(full),     32'(mq.size() == 16));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("clearing", 32'(clearing), 32'(m_clearing));
    if (m_busy_edge) check("scan_yield", 32'(wr_en), 32'(0));
  endtask

  task automatic cycle();
    @(posedge Clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    plot = 0; clear = 0;
  endtask

  task automatic set_push(input int px, input int py, input int pc);
    plot = 1; x = 8'(px); y = 7'(py); colour = 3'(pc);
  endtask

  // Runs an accepted clear to completion; returns the number of writes seen.
  task automatic run_clear(input bit toggle, input bit disturb, output int n);
    int k;
    n = 0;
    for (k = 0; k < 50000; k++) begin
      scan_busy = toggle ? (k % 2 == 1) : 1'b0;
      clear = 0; plot = 0;
      if (disturb && k == 100) begin clear = 1; clear_colour = 3'd7; end
      if (disturb && k == 200) set_push(7, 9, 3);
      cycle();
      if (wr_en) n++;
      if (!clearing) break;
    end
    if (k == 50000) check("clear_timeout", 32'(1), 32'(0));
    idle();
    scan_busy = 0;
  endtask

  initial begin
    int nw, k;

    // Reset
    resetn = 0;
    cycle(); cycle();
    check("rst_level", 32'(level), 32'(0));
    check("rst_wr_en", 32'(wr_en), 32'(0));
    resetn = 1;

    // Basic push: (3,2,5) -> address 323 two cycles later
    set_push(3, 2, 5);
    cycle();
    idle();
    cycle();
    check("basic_we",    32'(wr_en),   32'(1));
    check("basic_addr",  32'(wr_addr), 32'(323));
    check("basic_data",  32'(wr_data), 32'(5));
    check("basic_level", 32'(level),   32'(0));
    cycle();
    check("basic_one_pulse", 32'(wr_en), 32'(0));

    // Corner address and range filter
    set_push(159, 119, 6);
    cycle(); idle(); cycle();
    check("corner_addr", 32'(wr_addr), 32'(19199));
    set_push(160, 0, 1); cycle();
    set_push(0, 120, 2); cycle();
    idle(); cycle(); cycle();
    check("range_no_write", 32'(wr_en),    32'(0));
    check("range_no_ovf",   32'(overflow), 32'(0));
    check("range_level",    32'(level),    32'(0));

    // Scan-out stall: fill, overflow, then drain in order
    scan_busy = 1;
    for (int i = 0; i < 16; i++) begin
      set_push(i * 9, i * 7, i % 8);
      cycle();
    end
    check("stall_full",  32'(full),  32'(1));
    check("stall_level", 32'(level), 32'(16));
    set_push(20, 20, 3);
    cycle();
    check("stall_ovf", 32'(overflow), 32'(1));
    idle();
    scan_busy = 0;
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (wr_en) nw++;
    end
    check("stall_drain_count", 32'(nw), 32'(16));

    // Clear with queued pixels; second clear mid-run ignored
    scan_busy = 1;
    for (int i = 0; i < 4; i++) begin
      set_push(10 + i, 50 + i, i + 1);
      cycle();
    end
    idle();
    scan_busy = 0; clear = 1; clear_colour = 3'd0;
    cycle();
    check("clear_no_pop", 32'(wr_en), 32'(0));
    run_clear(1'b0, 1'b1, nw);
    check("clear_writes", 32'(nw), 32'(19200));
    nw = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (wr_en) nw++;
    end
    check("post_clear_pixels", 32'(nw), 32'(5));

    // Clear under scan contention
    clear = 1; clear_colour = 3'd2;
    cycle();
    run_clear(1'b1, 1'b0, nw);
    check("contended_clear_writes", 32'(nw), 32'(19200));

    // Reset mid-clear with pixels queued
    scan_busy = 1;
    for (int i = 0; i < 3; i++) begin
      set_push(i, i, 4);
      cycle();
    end
    idle();
    scan_busy = 0; clear = 1; clear_colour = 3'd5;
    cycle();
    clear = 0;
    for (k = 0; k < 6000; k++) begin
      cycle();
      if (wr_en && wr_addr == 15'd5000) break;
    end
    if (k == 6000) check("midclear_timeout", 32'(1), 32'(0));
    resetn = 0;
    cycle();
    check("mrst_we",       32'(wr_en),    32'(0));
    check("mrst_addr",     32'(wr_addr),  32'(0));
    check("mrst_data",     32'(wr_data),  32'(0));
    check("mrst_level",    32'(level),    32'(0));
    check("mrst_full",     32'(full),     32'(0));
    check("mrst_ovf",      32'(overflow), 32'(0));
    check("mrst_clearing", 32'(clearing), 32'(0));
    resetn = 1;
    cycle(); cycle();
    check("mrst_fifo_empty", 32'(wr_en), 32'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      plot   = ($urandom_range(0, 9) < 7);
      x      = 8'($urandom_range(0, 170));
      y      = 7'($urandom_range(0, 127));
      colour = 3'($urandom);
      scan_busy = ($urandom_range(0, 9) < 4);
      clear  = 0;
      resetn = ($urandom_range(0, 999) != 0);
      cycle();
    end
    resetn = 1;
    idle();
    scan_busy = 0;
    for (int i = 0; i < 20; i++) cycle();
    check("final_level", 32'(level), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_write_queue.md
# pixel_write_queue

Downstream stage of the bouncing-box drawer: accepts one (X, Y, colour) pixel per `iPlot` strobe and buffers it in a small FIFO. It converts each coordinate to a linear framebuffer address (Y*160 + X) and issues single-cycle writes to the 160x120x3 framebuffer RAM. Writes yield to the VGA scan-out reader through a one-cycle-ahead reservation signal. A clear engine can flood the whole framebuffer with one colour; pushes are still accepted while it runs.

## Interface
- `X_SCREENSIZE`, 160, pixels per line; also the address row stride.
- `Y_SCREENSIZE`, 120, number of lines.
- `FIFO_DEPTH`, 16, FIFO entries; must be a power of two.
- `ADDR_WIDTH`, 15, framebuffer address width; must satisfy 2^ADDR_WIDTH >= 19200.
- Reset `Resetn` is synchronous and active-low; the clock is `Clock`.
- `Clock`  in  1  system clock; every register updates on its rising edge.
- `Resetn`  in  1  synchronous, active-low reset.
- `iX`  in  8  pixel X coordinate.
- `iY`  in  7  pixel Y coordinate.
- `iColour`  in  3  pixel colour.
- `iPlot`  in  1  push strobe; one pixel per high cycle.
- `iClear`  in  1  start-clear pulse.
- `iClearColour`  in  3  fill colour, sampled when a clear is accepted.
- `iScanBusy`  in  1  scan-out reserves the RAM for the next cycle.
- `oWrAddr`  out  ADDR_WIDTH  framebuffer write address.
- `oWrData`  out  3  framebuffer write data.
- `oWrEn`  out  1  write strobe, one cycle per write.
- `oFull`  out  1  FIFO count == FIFO_DEPTH.
- `oLevel`  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- `oOverflow`  out  1  sticky: a push was lost.
- `oClearing`  out  1  clear engine active.

## Operation
- **Push qualification:** a push happens when `iPlot` = 1, `iX` < X_SCREENSIZE and `iY` < Y_SCREENSIZE.
  - An out-of-range pixel is silently discarded. It does not set `oOverflow`.
- **Push acceptance:** a qualified push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the pixel is lost and `oOverflow` is set. `oOverflow` is cleared only by reset.
- **Address arithmetic:**
  - The address is computed at pop time as (Y<<7) + (Y<<5) + X, zero-extended to ADDR_WIDTH. No multiplier is used.
  - The maximum address is 19199.
  - The FIFO stores raw X/Y/colour (18 bits per entry).
- **State machine, IDLE:**
  - Pop when the FIFO is non-empty and `iScanBusy` = 0.
  - If `iClear` = 1, go to CLEAR: latch `iClearColour`, set the clear counter to 0, and do no pop that cycle.
- **State machine, CLEAR:**
  - Each cycle with `iScanBusy` = 0, issue a write of the latched colour to the clear counter address, then increment the counter.
  - After the write to address X_SCREENSIZE*Y_SCREENSIZE-1 is issued, return to IDLE.
  - FIFO pops are blocked during CLEAR; pushes are still accepted.
  - `iClear` is ignored while in CLEAR.
- **Simultaneous events:**
  - `iClear` together with a non-empty FIFO: the clear wins, and the queued pixels are written after the clear finishes.
  - Push and pop on a full FIFO in the same cycle: both happen and the count is unchanged.
  - Push and pop on an empty FIFO in the same cycle: no pop, because a pushed entry is not visible until the next cycle.
- **Pointers:** read and write pointers wrap modulo FIFO_DEPTH. Count is tracked separately, so full and empty are unambiguous.
- **Output path:** `oWrAddr` / `oWrData` / `oWrEn` come from registers.
  - `oWrEn` is low in every cycle with no issued write.
  - `oWrAddr` and `oWrData` hold their last values when `oWrEn` is low.

## Timing
- **Reset values** (reset applied on any cycle, including mid-clear or mid-drain):
  - state IDLE, FIFO empty, `oLevel` = 0, `oFull` = 0.
  - `oOverflow` = 0, `oClearing` = 0, `oWrEn` = 0, `oWrAddr` = 0, `oWrData` = 0.
  - A write issued in the reset cycle does not appear.
- **`iScanBusy`:** when sampled high in cycle N, no write is issued at N+1, for either pop or clear.
- **Pop timing:** a pop decided in cycle N gives `oWrEn` = 1 with the matching address and data in cycle N+1.
- **Push latency:** a push in cycle N into an empty FIFO, with the path unblocked, gives `oWrEn` at N+2. The sustained throughput is 1 pixel per cycle.
- **Level and full:** `oLevel` and `oFull` reflect the count after the edge that updates it.
- **Clearing flag:**
  - `oClearing` goes high the cycle after `iClear` is accepted.
  - It goes low the cycle after the final clear write is issued, which is the same cycle that write appears on `oWrEn`.
  - An unobstructed clear produces 19200 consecutive `oWrEn` cycles.
- **Upstream compatibility:** the drawer's 16-pixel bursts at 1 pixel per cycle never overflow the FIFO when `iScanBusy` is low.

## Test plan
- **Reset and basic push:** reset, then push (X=3, Y=2, colour=5) -> two cycles later, one `oWrEn` pulse with `oWrAddr` = 323 and `oWrData` = 5; `oLevel` returns to 0.
- **Corner address and range filter:** push (159, 119) -> address 19199. Push (160, 0) and (0, 120) -> no write and `oOverflow` stays 0.
- **Scan-out stall:** push 16 pixels with `iScanBusy` held high -> `oFull` = 1, no writes. A 17th push -> `oOverflow` = 1. Drop `iScanBusy` -> 16 writes on consecutive cycles, in FIFO order.
- **Clear with queued pixels:** pulse `iClear` with `iClearColour` = 0 and 4 pixels queued -> 19200 writes of 0 to addresses 0..19199 in order, then the 4 pixels. A second `iClear` mid-run is ignored.
- **Clear under scan contention:** toggle `iScanBusy` every other cycle during the clear -> no `oWrEn` in any cycle after `iScanBusy` was high; total clear writes still 19200.
- **Reset mid-clear:** assert `Resetn` = 0 at clear address 5000 -> all outputs return to reset values on the next cycle, and the FIFO is empty.
